// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C slave receiver.
// State encoding is one-hot; ACK/NACK are the SDA levels of the 9th bit.
package i2c_pkg;

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        ADDR     = 6'b000010,
        ADDR_ACK = 6'b000100,
        DATA     = 6'b001000,
        DATA_ACK = 6'b010000,
        IGNORE   = 6'b100000
    } state_e;

    localparam int BIT_CNT_W = 4;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer, optional glitch filter and edge detect for one I2C line.
// Glitch filter is built only when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
        $error("i2c_line_sync: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   clean;
    logic                   prev_q;

    // Reset to the idle-bus level so leaving reset creates no false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] filt_cnt_q;
    logic          filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == CW'(FILT_LEN - 1)) begin
            filt_q     <= sync_q[SYNC_STAGES-1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + CW'(1);
        end
    end

    assign clean = filt_q;
`else
    assign clean = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= clean;
        end
    end

    assign level_o = clean;
    assign rise_o  = clean & ~prev_q;
    assign fall_o  = ~clean & prev_q;

endmodule

// File: rtl/i2c_slave_recv.sv
// Write-only I2C slave receiver: address match, byte shift-in, ACK/NACK.
// Optional input glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_recv
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       bus_start,
    output logic       bus_stop,
    output logic       nack_ovf
);

    localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(7);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda (
        .clk    (clk),
        .rst    (rst),
        .line_i (i2c_sda),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    state_e               state_q;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [7:0]           shift_q;
    logic [7:0]           shift_d;
    logic                 ack_q;
    logic                 sda_oe_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q;
    logic                 addr_match_q;
    logic                 bus_start_q;
    logic                 bus_stop_q;
    logic                 nack_ovf_q;
    logic                 start_det;
    logic                 stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign shift_d   = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            ack_q        <= NACK;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            bus_start_q  <= 1'b0;
            bus_stop_q   <= 1'b0;
            nack_ovf_q   <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            bus_start_q <= 1'b0;
            bus_stop_q  <= 1'b0;
            nack_ovf_q  <= 1'b0;
            if (start_det) begin
                state_q      <= ADDR;
                cnt_q        <= '0;
                addr_match_q <= 1'b0;
                bus_start_q  <= 1'b1;
            end else if (stop_det) begin
                state_q      <= IDLE;
                addr_match_q <= 1'b0;
                sda_oe_q     <= 1'b0;
                bus_stop_q   <= 1'b1;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise && cnt_q != CNT_FULL) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + BIT_CNT_W'(1);
                        end else if (scl_fall && cnt_q == CNT_FULL) begin
                            if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                                sda_oe_q <= 1'b1;
                                state_q  <= ADDR_ACK;
                            end else begin
                                state_q  <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q     <= 1'b0;
                            addr_match_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= DATA;
                        end
                    end
                    DATA: begin
                        if (scl_rise && cnt_q != CNT_FULL) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + BIT_CNT_W'(1);
                            // Byte is complete on this edge: hand off or refuse.
                            if (cnt_q == CNT_LAST) begin
                                if (rx_ready) begin
                                    rx_data_q  <= shift_d;
                                    rx_valid_q <= 1'b1;
                                    ack_q      <= ACK;
                                end else begin
                                    nack_ovf_q <= 1'b1;
                                    ack_q      <= NACK;
                                end
                            end
                        end else if (scl_fall && cnt_q == CNT_FULL) begin
                            sda_oe_q <= (ack_q == ACK);
                            state_q  <= DATA_ACK;
                        end
                    end
                    DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= '0;
                            state_q  <= (ack_q == ACK) ? DATA : IGNORE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign i2c_sda    = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign bus_start  = bus_start_q;
    assign bus_stop   = bus_stop_q;
    assign nack_ovf   = nack_ovf_q;

endmodule

// File: tb/tb_i2c_slave_recv.sv
// Directed bench for i2c_slave_recv with a byte scoreboard and pulse monitor.
`timescale 1ns/1ps
module tb_i2c_slave_recv;

    localparam int Q = 50;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic       rx_ready;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       bus_start;
    logic       bus_stop;
    logic       nack_ovf;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_recv #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_scl   (scl),
        .i2c_sda   (sda_w),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_match(addr_match),
        .bus_start (bus_start),
        .bus_stop  (bus_stop),
        .nack_ovf  (nack_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_start = 0, n_stop = 0, n_nack = 0, n_slow = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic m_start();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic m_stop();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic m_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
        end
    endtask

    task automatic m_byte(input string nm, input logic [7:0] b, input logic exp_sda);
        logic a;
        m_bits(b, 8);
        m_low = 1'b0; #Q; scl = 1'b1; #Q;
        a = sda_w;
        #Q; scl = 1'b0; #Q;
        chk(nm, a, exp_sda);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int s_v, s_st, s_sp, s_n, s_sl;
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; rx_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rx_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rx_unexpected act=%0h exp=none", rx_data);
                    end else begin
                        chk("sb_rx_data", rx_data, exp_q.pop_front());
                    end
                end
                n_start += int'(bus_start);
                n_stop  += int'(bus_stop);
                n_nack  += int'(nack_ovf);
                if (sda_w === 1'b0 && !m_low) n_slow++;
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_outs", {rx_valid, addr_match, bus_start, bus_stop, nack_ovf}, 5'b0);
        chk("rst_sda", sda_w, 1'b1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: addressed write of A5
        s_v = n_valid; s_st = n_start; s_sp = n_stop;
        m_start();
        m_byte("t1_addr_ack", 8'hA0, 1'b0);
        chk("t1_match", addr_match, 1'b1);
        exp_q.push_back(8'hA5);
        m_byte("t1_data_ack", 8'hA5, 1'b0);
        m_stop();
        repeat (5) @(negedge clk);
        chk("t1_match_off", addr_match, 1'b0);
        chk("t1_starts", n_start - s_st, 1);
        chk("t1_stops", n_stop - s_sp, 1);
        chk("t1_valids", n_valid - s_v, 1);

        // 2: wrong address
        s_v = n_valid; s_sl = n_slow;
        m_start();
        m_byte("t2_addr_nack", 8'hA2, 1'b1);
        chk("t2_match", addr_match, 1'b0);
        m_byte("t2_data_nack", 8'h3C, 1'b1);
        m_stop();
        repeat (5) @(negedge clk);
        chk("t2_never_low", n_slow - s_sl, 0);
        chk("t2_valids", n_valid - s_v, 0);

        // 3: read request
        s_v = n_valid;
        m_start();
        m_byte("t3_read_nack", 8'hA1, 1'b1);
        m_byte("t3_ignored", 8'h55, 1'b1);
        chk("t3_valids", n_valid - s_v, 0);
        m_stop();
        repeat (5) @(negedge clk);

        // 4: second byte refused by core
        s_v = n_valid; s_n = n_nack;
        m_start();
        m_byte("t4_addr_ack", 8'hA0, 1'b0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h11);
        m_byte("t4_b1_ack", 8'h11, 1'b0);
        rx_ready = 1'b0;
        m_byte("t4_b2_nack", 8'h22, 1'b1);
        m_stop();
        repeat (5) @(negedge clk);
        rx_ready = 1'b1;
        chk("t4_valids", n_valid - s_v, 1);
        chk("t4_nacks", n_nack - s_n, 1);
        chk("t4_rx_data", rx_data, 8'h11);

        // 5: repeated START after a partial byte
        s_v = n_valid; s_st = n_start;
        m_start();
        m_byte("t5_addr_ack", 8'hA0, 1'b0);
        m_bits(8'hC3, 4);
        m_start();
        m_byte("t5_addr2_ack", 8'hA0, 1'b0);
        exp_q.push_back(8'hFF);
        m_byte("t5_data_ack", 8'hFF, 1'b0);
        m_stop();
        repeat (5) @(negedge clk);
        chk("t5_starts", n_start - s_st, 2);
        chk("t5_valids", n_valid - s_v, 1);
        chk("t5_rx_data", rx_data, 8'hFF);

        // 6: reset while the slave holds the address ACK
        m_start();
        m_bits(8'hA0, 8);
        m_low = 1'b0;
        for (int i = 0; i < 20 && sda_w !== 1'b0; i++) @(negedge clk);
        chk("t6_ack_driven", sda_w, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_sda_released", sda_w, 1'b1);
        chk("t6_rx_data", rx_data, 8'h00);
        chk("t6_outs", {rx_valid, addr_match, bus_start, bus_stop, nack_ovf}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        scl = 1'b1; #Q; scl = 1'b0; #Q;
        m_stop();
        repeat (5) @(negedge clk);
        s_v = n_valid;
        m_start();
        m_byte("t6_re_addr_ack", 8'hA0, 1'b0);
        exp_q.push_back(8'h5A);
        m_byte("t6_re_data_ack", 8'h5A, 1'b0);
        m_stop();
        repeat (5) @(negedge clk);
        chk("t6_valids", n_valid - s_v, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_recv.md
Name: i2c_slave_recv

Overview:
- I2C slave receiver; the far end of the byte-sending I2C master.
- Oversamples i2c_scl/i2c_sda on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, shifts in write-data bytes MSB first and drives ACK/NACK on the open-drain SDA.
- Delivers each byte to core logic with a one-cycle valid pulse; write-only target, read requests are NACKed.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchronizer flops on i2c_scl/i2c_sda (minimum 2).
- FILT_LEN, 3, glitch-filter depth in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; must be >= 8x the SCL rate.
- rst  input  1  synchronous reset, active-high.
- i2c_scl  input  1  I2C clock from the master.
- i2c_sda  inout  1  I2C data; the slave drives only 1'b0 or 1'bz.
- rx_ready  input  1  core can accept a byte; sampled at the 8th data bit.
- rx_data  output  8  last received data byte.
- rx_valid  output  1  one-cycle pulse; rx_data is valid this cycle.
- addr_match  output  1  high from address ACK until STOP or repeated START.
- bus_start  output  1  one-cycle pulse on each START or repeated START.
- bus_stop  output  1  one-cycle pulse on STOP.
- nack_ovf  output  1  one-cycle pulse when a byte is NACKed because rx_ready=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst); all flops clear on posedge clk while rst=1.
- Reset values: rx_data=8'h00; rx_valid, addr_match, bus_start, bus_stop, nack_ovf = 0; SDA released (z); state=IDLE; bit counter=0. Reset mid-transfer releases SDA on the next clk edge.
- Input path: SYNC_STAGES-flop synchronizer per line, plus one previous-value register. Edges are derived from synchronized values only.
- START: SDA falls while SCL is high. Valid in any state. Effects: next state ADDR, counter cleared, addr_match cleared, bus_start pulses.
- STOP: SDA rises while SCL is high. Valid in any state. Effects: next state IDLE, addr_match cleared, SDA released, bus_stop pulses.
- START/STOP take priority over any data edge detected in the same cycle.
- Data sampling: on each synchronized SCL rising edge; bit shifts into the LSB of the shift register (MSB first on the wire). Counter runs 0..8.
- States:
  - IDLE: SDA released; only START is recognized.
  - ADDR: collect 8 bits (7 address + R/W). At the SCL falling edge after bit 8:
    - address == SLAVE_ADDR and R/W=0: drive SDA low, go to ADDR_ACK.
    - otherwise: leave SDA released (NACK), go to IGNORE.
  - ADDR_ACK: hold SDA low through the 9th SCL high. Release on the next SCL falling edge, set addr_match=1, go to DATA.
  - DATA: collect 8 bits. On the clk after the 8th SCL rising edge:
    - rx_ready=1: rx_data<=shift register, rx_valid pulses, byte is ACKed.
    - rx_ready=0: nack_ovf pulses, rx_data unchanged, byte is NACKed.
    - At the following SCL falling edge, drive SDA low for ACK; go to DATA_ACK.
  - DATA_ACK: release SDA on the next SCL falling edge. ACK → DATA (counter=0). NACK → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- SDA is changed only in the clk cycle after a synchronized SCL falling edge, never while SCL is high.
- Latency: rx_valid is asserted SYNC_STAGES+1 clk cycles after the physical 8th SCL rise.
- Counter never wraps past 8; a STOP or START mid-byte discards the partial byte.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a FILT_LEN-deep filter. The filtered output changes only after FILT_LEN consecutive equal samples, which rejects spikes shorter than FILT_LEN clk cycles. Latency grows by FILT_LEN cycles.
- Undefined: filter absent; synchronizer output is used directly.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding constants IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, one-hot 6-bit;
  - BIT_CNT_W=4;
  - ACK=1'b0 and NACK=1'b1.
- Sub-module i2c_line_sync: synchronizer, optional glitch filter, and rise/fall edge detect for one line. Instantiated twice (SCL, SDA).

Test Plan:
- START, addr 0x50 W, data 0xA5, STOP, rx_ready=1:
  - bus_start pulses once; ACK low at both 9th clocks;
  - rx_valid pulses once with rx_data=8'hA5; bus_stop pulses; addr_match is 0 after STOP.
- START, addr 0x51 W, data 0x3C:
  - SDA never driven low; no rx_valid; addr_match stays 0.
- START, addr 0x50 R (byte 8'hA1):
  - NACK; state IGNORE; no rx_valid until the next START.
- Address ACKed, then data 0x11 with rx_ready=1 and data 0x22 with rx_ready=0:
  - rx_valid once with 8'h11; nack_ovf once; rx_data stays 8'h11; 2nd byte NACKed.
- Repeated START after 4 data bits, then addr 0x50 W, data 0xFF:
  - partial byte dropped; bus_start pulses twice; rx_data=8'hFF.
- rst asserted while SDA driven low at the 9th bit:
  - SDA is z on the next clk edge; all outputs return to 0; state IDLE.
